qam_mapper_adaptive: RTL and testbench

Parametrised, mode-selectable QAM mapper with a registered valid/ready output stage. It maps N parallel symbols per beat to I/Q amplitudes in QPSK, QAM16 or QAM64 at run time. Constellation levels are derived from a programmable peak amplitude by an on-chip sequential divider, so no DSP slices are used. It sits between the bit clusterer and the IFFT input in the Fourier transmitter datapath.

---
 rtl/qam_mapper_adaptive.sv | 195 +++++++++++++++++++
 tb/tb_qam_mapper_adaptive.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam_mapper_adaptive.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : qam_mapper_adaptive
//  Description : Run-time selectable QPSK/QAM16/QAM64 mapper for N parallel
//                symbols per beat. Constellation levels come from a
//                programmable peak amplitude via a bit-serial restoring
//                divider, so no multipliers are needed. The output stage is a
//                registered valid/ready stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module qam_mapper_adaptive #(
   parameter int N = 16,
   parameter int W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_load,
   input  logic [1:0]       cfg_mode,
   input  logic [W-1:0]     cfg_last,
   output logic             cfg_busy,
   output logic             cfg_done,
   input  logic [6*N-1:0]   in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [W*N-1:0]   I,
   output logic [W*N-1:0]   Q,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam logic [1:0] C_MODE_QAM16 = 2'd1;
   localparam logic [1:0] C_MODE_QAM64 = 2'd2;
   localparam int         C_CW         = (W > 2) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      S_UNCFG = 2'd0,
      S_DIV   = 2'd1,
      S_SCALE = 2'd2,
      S_RUN   = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_busy;
   logic              r_done;
   // Active levels used by the mapper
   logic [1:0]        r_mode;
   logic [W-1:0]      r_p1;
   logic [W-1:0]      r_p3;
   logic [W-1:0]      r_p5;
   logic [W-1:0]      r_last;
   // Pending configuration, committed only when the new levels are complete
   logic [1:0]        r_new_mode;
   logic [W-1:0]      r_new_last;
   // Divider: r_quo shifts the dividend out of its MSB and quotient bits in
   logic [W-1:0]      r_quo;
   logic [2:0]        r_rem;
   logic [C_CW-1:0]   r_cnt;

   logic [W*N-1:0]    r_i;
   logic [W*N-1:0]    r_q;
   logic              r_ovalid;

   logic [2:0]        w_d;
   logic [3:0]        w_shift;
   logic [3:0]        w_sub;
   logic              w_ge;
   logic              w_accept;
   logic [W*N-1:0]    w_i;
   logic [W*N-1:0]    w_q;

   // Divisor: 7 yields QAM64 spacing, 3 yields QAM16 spacing (QPSK ignores it)
   assign w_d      = (r_new_mode == C_MODE_QAM64) ? 3'd7 : 3'd3;
   assign w_shift  = {r_rem, r_quo[W-1]};
   assign w_sub    = w_shift - {1'b0, w_d};
   assign w_ge     = (w_shift >= {1'b0, w_d});

   assign in_ready = (r_state == S_RUN) & (~r_ovalid | out_ready);
   assign w_accept = in_valid & in_ready;

   assign cfg_busy  = r_busy;
   assign cfg_done  = r_done;
   assign I         = r_i;
   assign Q         = r_q;
   assign out_valid = r_ovalid;

   // Level for one axis: hi/mid/lo are the bits steering that axis (MSB = sign)
   function automatic logic [W-1:0] f_level(
      input logic [1:0]   mode,
      input logic         hi,
      input logic         mid,
      input logic         lo,
      input logic [W-1:0] p1,
      input logic [W-1:0] p3,
      input logic [W-1:0] p5,
      input logic [W-1:0] last
   );
      logic [W-1:0] mag;
      logic         neg;
      mag = last;
      neg = lo;
      if (mode == C_MODE_QAM64) begin
         neg = hi;
         case ({mid, lo})
            2'b00:   mag = p1;
            2'b01:   mag = p3;
            2'b10:   mag = p5;
            default: mag = last;
         endcase
      end else if (mode == C_MODE_QAM16) begin
         neg = mid;
         mag = lo ? last : p1;
      end
      return neg ? ({W{1'b0}} - mag) : mag;
   endfunction

   generate
      for (genvar k = 0; k < N; k++) begin : g_sym
         assign w_i[W*k +: W] = f_level(r_mode, in_data[6*k+5], in_data[6*k+3], in_data[6*k+1],
                                        r_p1, r_p3, r_p5, r_last);
         assign w_q[W*k +: W] = f_level(r_mode, in_data[6*k+4], in_data[6*k+2], in_data[6*k+0],
                                        r_p1, r_p3, r_p5, r_last);
      end
   endgenerate

   // Configuration FSM: accept config, run the serial divide, scale and commit levels
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_UNCFG;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_mode     <= 2'd0;
         r_p1       <= '0;
         r_p3       <= '0;
         r_p5       <= '0;
         r_last     <= '0;
         r_new_mode <= 2'd0;
         r_new_last <= '0;
         r_quo      <= '0;
         r_rem      <= '0;
         r_cnt      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_UNCFG, S_RUN: begin
               if (cfg_load) begin
                  r_new_mode <= cfg_mode;
                  r_new_last <= cfg_last;
                  r_quo      <= cfg_last;
                  r_rem      <= '0;
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= S_DIV;
               end
            end
            S_DIV: begin
               r_quo <= {r_quo[W-2:0], w_ge};
               r_rem <= w_ge ? w_sub[2:0] : w_shift[2:0];
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == C_CW'(W-1)) begin
                  r_state <= S_SCALE;
               end
            end
            S_SCALE: begin
               r_mode  <= r_new_mode;
               r_last  <= r_new_last;
               r_p1    <= r_quo;
               r_p3    <= (r_quo << 1) + r_quo;
               r_p5    <= (r_quo << 2) + r_quo;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_RUN;
            end
            default: r_state <= S_UNCFG;
         endcase
      end
   end

   // Output register: load on accepted beat, hold while stalled, clear on drain
   always_ff @(posedge clk) begin
      if (rst) begin
         r_i      <= '0;
         r_q      <= '0;
         r_ovalid <= 1'b0;
      end else if (w_accept) begin
         r_i      <= w_i;
         r_q      <= w_q;
         r_ovalid <= 1'b1;
      end else if (out_ready) begin
         r_ovalid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_qam_mapper_adaptive.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_qam_mapper_adaptive
//  Description : Directed self-checking bench for qam_mapper_adaptive
//                (N=2 symbols per beat, W=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qam_mapper_adaptive;

   localparam int N = 2;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           cfg_load;
   logic [1:0]     cfg_mode;
   logic [W-1:0]   cfg_last;
   logic           cfg_busy;
   logic           cfg_done;
   logic [6*N-1:0] in_data;
   logic           in_valid;
   logic           in_ready;
   logic [W*N-1:0] I;
   logic [W*N-1:0] Q;
   logic           out_valid;
   logic           out_ready;

   int n_chk  = 0;
   int n_fail = 0;

   // QAM64 levels for last=7000, indexed by 3-bit axis code
   logic [15:0] lvl64 [8] = '{16'h03E8, 16'h0BB8, 16'h1388, 16'h1B58,
                              16'hFC18, 16'hF448, 16'hEC78, 16'hE4A8};

   qam_mapper_adaptive #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_load  (cfg_load),
      .cfg_mode  (cfg_mode),
      .cfg_last  (cfg_last),
      .cfg_busy  (cfg_busy),
      .cfg_done  (cfg_done),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .I         (I),
      .Q         (Q),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Build a 6-bit symbol from the I and Q axis codes
   function automatic logic [5:0] sym64(input logic [2:0] ci, input logic [2:0] cq);
      return {ci[2], cq[2], ci[1], cq[1], ci[0], cq[0]};
   endfunction

   // Load a configuration and check the busy/done/in_ready timeline
   task automatic do_cfg(input logic [1:0] m, input logic [15:0] last);
      cfg_mode = m;
      cfg_last = last;
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      for (int k = 0; k <= W; k++) begin
         chk("cfg_busy_on", cfg_busy, 1'b1);
         chk("cfg_done_low", cfg_done, 1'b0);
         chk("in_ready_cfg", in_ready, 1'b0);
         tick();
      end
      chk("cfg_busy_off", cfg_busy, 1'b0);
      chk("cfg_done_pulse", cfg_done, 1'b1);
      chk("in_ready_after_cfg", in_ready, 1'b1);
      tick();
      chk("cfg_done_one_cycle", cfg_done, 1'b0);
   endtask

   // Send a single beat with out_ready=1 and check both symbols
   task automatic beat(input string tag, input logic [11:0] d,
                       input logic [15:0] i0, input logic [15:0] q0,
                       input logic [15:0] i1, input logic [15:0] q1);
      in_data   = d;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_I0"}, I[15:0], i0);
      chk({tag, "_Q0"}, Q[15:0], q0);
      chk({tag, "_I1"}, I[31:16], i1);
      chk({tag, "_Q1"}, Q[31:16], q1);
      tick();
      chk({tag, "_drained"}, out_valid, 1'b0);
   endtask

   initial begin
      int          sent;
      int          consumed;
      logic        m_ov;
      logic        exp_ir;
      logic        acc;
      logic        drain;
      logic [5:0]  s;
      logic [2:0]  pat;

      rst = 1'b1; cfg_load = 1'b0; cfg_mode = 2'd0; cfg_last = '0;
      in_data = '0; in_valid = 1'b0; out_ready = 1'b1;

      // 1. Reset and unconfigured behaviour
      tick(); tick(); tick();
      chk("rst_busy", cfg_busy, 1'b0);
      chk("rst_done", cfg_done, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      rst = 1'b0;
      in_valid = 1'b1;
      in_data  = 12'hFFF;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("uncfg_in_ready", in_ready, 1'b0);
         chk("uncfg_out_valid", out_valid, 1'b0);
         chk("uncfg_I", I, 32'h0);
         chk("uncfg_Q", Q, 32'h0);
      end
      in_valid = 1'b0;

      // 2. QAM64, last=7000 -> p1=1000, p3=3000, p5=5000
      do_cfg(2'd2, 16'd7000);
      beat("qam64", {6'b011001, 6'b101010}, 16'hE4A8, 16'h03E8, 16'h1388, 16'hF448);

      // 3. QAM16 (b5,b4 ignored) and QPSK
      do_cfg(2'd1, 16'd3000);
      beat("qam16", {6'b110000, 6'b000110}, 16'h0BB8, 16'hFC18, 16'h03E8, 16'h03E8);
      do_cfg(2'd0, 16'd3000);
      beat("qpsk", {6'b111110, 6'b000001}, 16'h0BB8, 16'hF448, 16'hF448, 16'h0BB8);

      // 4. Backpressure with out_ready pattern 1,0,0 repeating
      do_cfg(2'd2, 16'd7000);
      sent = 0; consumed = 0; m_ov = 1'b0; pat = 3'b001;
      for (int cyc = 0; cyc < 60 && consumed < 8; cyc++) begin
         out_ready = pat[cyc % 3];
         in_valid  = (sent < 8);
         s         = sym64(3'(sent), 3'(7 - sent));
         in_data   = {s, s};
         #3;
         exp_ir = ~(m_ov & ~out_ready);
         chk("bp_in_ready", in_ready, exp_ir);
         chk("bp_out_valid", out_valid, m_ov);
         if (m_ov) begin
            chk("bp_I0", I[15:0], lvl64[consumed]);
            chk("bp_Q0", Q[15:0], lvl64[7 - consumed]);
            chk("bp_I1", I[31:16], lvl64[consumed]);
         end
         acc   = in_valid & exp_ir;
         drain = m_ov & out_ready;
         tick();
         if (drain) consumed++;
         if (acc)   sent++;
         m_ov = acc ? 1'b1 : (drain ? 1'b0 : m_ov);
      end
      chk("bp_consumed", 32'(consumed), 32'd8);
      chk("bp_sent", 32'(sent), 32'd8);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();

      // 5. Reconfigure to QPSK with a QAM64 beat stalled in the output register
      in_data   = {sym64(3'd2, 3'd5), sym64(3'd2, 3'd5)};
      in_valid  = 1'b1;
      out_ready = 1'b0;
      tick();
      in_data  = {6'b101010, 6'b101010};
      cfg_mode = 2'd0;
      cfg_last = 16'd3000;
      cfg_load = 1'b1;
      #1;
      chk("rc_in_ready_load", in_ready, 1'b0);
      tick();
      cfg_load = 1'b0;
      for (int k = 0; k <= W; k++) begin
         if (k == 2) out_ready = 1'b1;
         if (k == 3) begin
            cfg_mode = 2'd2;
            cfg_last = 16'd7000;
            cfg_load = 1'b1;
         end
         if (k == 4) cfg_load = 1'b0;
         #1;
         chk("rc_busy", cfg_busy, 1'b1);
         chk("rc_in_ready", in_ready, 1'b0);
         chk("rc_out_valid", out_valid, (k <= 2) ? 1'b1 : 1'b0);
         if (k <= 2) begin
            chk("rc_stalled_I", I[15:0], 16'h1388);
            chk("rc_stalled_Q", Q[15:0], 16'hF448);
         end
         tick();
      end
      chk("rc_done", cfg_done, 1'b1);
      chk("rc_busy_off", cfg_busy, 1'b0);
      chk("rc_in_ready_back", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("rc_qpsk_valid", out_valid, 1'b1);
      chk("rc_qpsk_I", I[15:0], 16'hF448);
      chk("rc_qpsk_Q", Q[15:0], 16'h0BB8);
      chk("rc_no_reload", cfg_busy, 1'b0);
      tick();

      // 6. Reset in the middle of a division
      in_data   = {sym64(3'd1, 3'd1), sym64(3'd1, 3'd1)};
      in_valid  = 1'b1;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("rd_pre_valid", out_valid, 1'b1);
      cfg_mode = 2'd2;
      cfg_last = 16'd7000;
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      chk("rd_busy", cfg_busy, 1'b0);
      chk("rd_out_valid", out_valid, 1'b0);
      chk("rd_in_ready", in_ready, 1'b0);
      chk("rd_I", I, 32'h0);
      in_valid = 1'b1;
      tick();
      chk("rd_uncfg_busy", cfg_busy, 1'b0);
      chk("rd_uncfg_in_ready", in_ready, 1'b0);
      in_valid = 1'b0;
      // Full-scale last: p1=9362, p5=46810 (0xB6DA)
      do_cfg(2'd2, 16'hFFFF);
      beat("rd_qam64", {sym64(3'd1, 3'd3), sym64(3'd2, 3'd6)},
           16'hB6DA, 16'h4926, 16'h6DB6, 16'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
